phys_reg_tracker: RTL and testbench

//  Next-generation R10K physical-register bookkeeping: unified free list, ready (complete) table
//  and internal branch-checkpoint store in one block. Sits between dispatch, CDB, retire and

---
 rtl/phys_reg_tracker_pkg.sv | 38 +++
 rtl/phys_reg_tracker_prio_pick_n.sv | 38 +++
 rtl/phys_reg_tracker.sv | 158 +++++++++++++++
 tb/tb_phys_reg_tracker.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/phys_reg_tracker_pkg.sv
// Shared sizes, types and helpers for the physical-register tracker.
// Holds the checkpoint entry layout and the reset images of the free and ready tables.
package phys_reg_tracker_pkg;

    localparam int NUM_PREGS = 64;
    localparam int NUM_AREGS = 32;
    localparam int WIDTH     = 3;
    localparam int NUM_CKPT  = 4;

    localparam int PREG_W = $clog2(NUM_PREGS);
    localparam int CKPT_W = $clog2(NUM_CKPT);
    localparam int CNT_W  = $clog2(WIDTH + 1);
    localparam int FCNT_W = $clog2(NUM_PREGS) + 1;

    typedef logic [PREG_W-1:0] preg_idx_t;
    typedef logic [CKPT_W-1:0] ckpt_tag_t;

    typedef struct packed {
        logic                 valid;
        logic [NUM_CKPT-1:0]  younger_mask;
        logic [NUM_PREGS-1:0] free_snapshot;
    } ckpt_entry_t;

    // Architectural pregs 0..NUM_AREGS-1 hold the reset map: ready, not free.
    localparam logic [NUM_PREGS-1:0] READY_RESET =
        {{(NUM_PREGS - NUM_AREGS){1'b0}}, {NUM_AREGS{1'b1}}};
    localparam logic [NUM_PREGS-1:0] FREE_RESET = ~READY_RESET;

    function automatic logic [FCNT_W-1:0] count_ones(input logic [NUM_PREGS-1:0] v);
        logic [FCNT_W-1:0] ones;
        ones = '0;
        for (int i = 0; i < NUM_PREGS; i++) begin
            ones = ones + FCNT_W'(v[i]);
        end
        return ones;
    endfunction

endpackage

// File: rtl/phys_reg_tracker_prio_pick_n.sv
// Priority picker: returns the indices of the WIDTH lowest set bits of vec, lane 0 lowest,
// plus how many were found (saturating at WIDTH).
module prio_pick_n #(
    parameter  int N     = 64,
    parameter  int WIDTH = 3,
    localparam int IDX_W = $clog2(N),
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [N-1:0]                 vec,
    output logic [WIDTH-1:0][IDX_W-1:0]  idx,
    output logic [CNT_W-1:0]             count
);

    logic [N-1:0] rem;
    logic         found;

    always_comb begin
        rem   = vec;
        idx   = '0;
        count = '0;
        found = 1'b0;
        for (int lane = 0; lane < WIDTH; lane++) begin
            found = 1'b0;
            // Scan downward so the last hit recorded is the lowest set bit.
            for (int b = N - 1; b >= 0; b--) begin
                if (rem[b]) begin
                    idx[lane] = IDX_W'(b);
                    found     = 1'b1;
                end
            end
            if (found) begin
                rem[idx[lane]] = 1'b0;
                count          = count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/phys_reg_tracker.sv
// R10K-style physical register bookkeeping: free list, ready table and internally
// patched branch checkpoints, so a mispredict restore is always exact.
module phys_reg_tracker
    import phys_reg_tracker_pkg::*;
(
    input  logic                      clock,
    input  logic                      reset,
    input  logic [CNT_W-1:0]          alloc_req_cnt,
    output logic [CNT_W-1:0]          alloc_grant_cnt,
    output logic [WIDTH*PREG_W-1:0]   alloc_preg,
    output logic [FCNT_W-1:0]         free_cnt,
    input  logic [WIDTH-1:0]          complete_valid,
    input  logic [WIDTH*PREG_W-1:0]   complete_preg,
    input  logic [CNT_W-1:0]          retire_cnt,
    input  logic [WIDTH*PREG_W-1:0]   retire_preg,
    input  logic                      ckpt_take,
    output ckpt_tag_t                 ckpt_tag,
    output logic                      ckpt_full,
    input  logic                      br_valid,
    input  ckpt_tag_t                 br_tag,
    input  logic                      br_mispredict,
    output logic [NUM_PREGS-1:0]      ready_list,
    output logic [NUM_PREGS-1:0]      next_ready_list
);

    logic [NUM_PREGS-1:0] free_reg, free_next, free_after;
    logic [NUM_PREGS-1:0] ready_reg, ready_next;
    logic [FCNT_W-1:0]    free_cnt_reg;
    logic                 ckpt_full_reg;
    ckpt_entry_t          ckpt_reg  [NUM_CKPT];
    ckpt_entry_t          ckpt_next [NUM_CKPT];
    logic [NUM_CKPT-1:0]  valid_vec, valid_next, kill_mask, br_onehot;

    logic [WIDTH-1:0][PREG_W-1:0] pick_idx;
    logic [CNT_W-1:0]             pick_cnt;
    logic [0:0][CKPT_W-1:0]       slot_idx;
    logic [0:0]                   slot_cnt;

    logic [NUM_PREGS-1:0] alloc_onehot    [WIDTH];
    logic [NUM_PREGS-1:0] retire_onehot   [WIDTH];
    logic [NUM_PREGS-1:0] complete_onehot [WIDTH];
    logic [NUM_PREGS-1:0] alloc_mask, retire_mask, complete_mask;

    logic mispredict, resolve_ok, take_ok;

    prio_pick_n #(.N(NUM_PREGS), .WIDTH(WIDTH)) u_alloc_pick (
        .vec   (free_reg),
        .idx   (pick_idx),
        .count (pick_cnt)
    );

    prio_pick_n #(.N(NUM_CKPT), .WIDTH(1)) u_slot_pick (
        .vec   (~valid_vec),
        .idx   (slot_idx),
        .count (slot_cnt)
    );

    assign br_onehot  = NUM_CKPT'(1) << br_tag;
    assign mispredict = br_valid & br_mispredict & ckpt_reg[br_tag].valid;
    assign resolve_ok = br_valid & ~br_mispredict & ckpt_reg[br_tag].valid;
    assign take_ok    = ckpt_take & ~ckpt_full_reg & ~mispredict & slot_cnt[0];
    assign ckpt_tag   = slot_idx[0];

    // A restore overrides anything dispatch would have renamed this cycle.
    assign alloc_grant_cnt = mispredict ? '0 :
                             (alloc_req_cnt < pick_cnt) ? alloc_req_cnt : pick_cnt;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lane
            assign alloc_preg[gi*PREG_W +: PREG_W] = pick_idx[gi];
            assign alloc_onehot[gi] = (CNT_W'(gi) < alloc_grant_cnt) ?
                                      (NUM_PREGS'(1) << pick_idx[gi]) : '0;
            // preg 0 is permanently mapped and must never reach the free list.
            assign retire_onehot[gi] =
                ((CNT_W'(gi) < retire_cnt) && (retire_preg[gi*PREG_W +: PREG_W] != '0)) ?
                (NUM_PREGS'(1) << retire_preg[gi*PREG_W +: PREG_W]) : '0;
            assign complete_onehot[gi] = complete_valid[gi] ?
                (NUM_PREGS'(1) << complete_preg[gi*PREG_W +: PREG_W]) : '0;
        end
        for (genvar gi = 0; gi < NUM_CKPT; gi++) begin : g_valid
            assign valid_vec[gi] = ckpt_reg[gi].valid;
        end
    endgenerate

    always_comb begin
        alloc_mask    = '0;
        retire_mask   = '0;
        complete_mask = '0;
        for (int i = 0; i < WIDTH; i++) begin
            alloc_mask    = alloc_mask    | alloc_onehot[i];
            retire_mask   = retire_mask   | retire_onehot[i];
            complete_mask = complete_mask | complete_onehot[i];
        end
    end

    assign free_after = (free_reg & ~alloc_mask) | retire_mask;
    assign free_next  = mispredict ? (ckpt_reg[br_tag].free_snapshot | retire_mask) : free_after;
    assign ready_next = (ready_reg & ~alloc_mask) | complete_mask;

    always_comb begin
        kill_mask = '0;
        if (mispredict) begin
            kill_mask = ckpt_reg[br_tag].younger_mask | br_onehot;
        end else if (resolve_ok) begin
            kill_mask = br_onehot;
        end
    end

    // Retire frees are folded into every live snapshot so restores never resurrect stale maps.
    always_comb begin
        valid_next = '0;
        for (int s = 0; s < NUM_CKPT; s++) begin
            ckpt_next[s].valid         = ckpt_reg[s].valid & ~kill_mask[s];
            ckpt_next[s].younger_mask  = ckpt_reg[s].younger_mask & ~kill_mask;
            ckpt_next[s].free_snapshot = ckpt_reg[s].free_snapshot | retire_mask;
            if (take_ok) begin
                if (CKPT_W'(s) == ckpt_tag) begin
                    ckpt_next[s].valid         = 1'b1;
                    ckpt_next[s].younger_mask  = '0;
                    ckpt_next[s].free_snapshot = free_after;
                end else if (ckpt_next[s].valid) begin
                    ckpt_next[s].younger_mask[ckpt_tag] = 1'b1;
                end
            end
            valid_next[s] = ckpt_next[s].valid;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            free_reg      <= FREE_RESET;
            ready_reg     <= READY_RESET;
            free_cnt_reg  <= FCNT_W'(NUM_PREGS - NUM_AREGS);
            ckpt_full_reg <= 1'b0;
            for (int s = 0; s < NUM_CKPT; s++) begin
                ckpt_reg[s] <= '0;
            end
        end else begin
            free_reg      <= free_next;
            ready_reg     <= ready_next;
            free_cnt_reg  <= count_ones(free_next);
            ckpt_full_reg <= &valid_next;
            for (int s = 0; s < NUM_CKPT; s++) begin
                ckpt_reg[s] <= ckpt_next[s];
            end
        end
    end

    assign free_cnt        = free_cnt_reg;
    assign ckpt_full       = ckpt_full_reg;
    assign ready_list      = ready_reg;
    assign next_ready_list = ready_reg | complete_mask;

    // Releasing a preg that is already free points at a rename/retire bookkeeping bug upstream.
    a_retire_not_free: assert property (@(posedge clock) disable iff (!reset)
        (retire_mask & free_reg) == '0);

endmodule

// File: tb/tb_phys_reg_tracker.sv
// Bench for phys_reg_tracker: directed vector table, hand-written corner sequences and
// randomized traffic checked against a set/sequence-number reference model.
module tb_phys_reg_tracker;
    import phys_reg_tracker_pkg::*;

    logic                    clock = 1'b0;
    logic                    reset;
    logic [CNT_W-1:0]        alloc_req_cnt, alloc_grant_cnt, retire_cnt;
    logic [WIDTH*PREG_W-1:0] alloc_preg, complete_preg, retire_preg;
    logic [FCNT_W-1:0]       free_cnt;
    logic [WIDTH-1:0]        complete_valid;
    logic                    ckpt_take, ckpt_full, br_valid, br_mispredict;
    ckpt_tag_t               ckpt_tag, br_tag;
    logic [NUM_PREGS-1:0]    ready_list, next_ready_list;

    always #5 clock = ~clock;

    phys_reg_tracker dut (
        .clock(clock), .reset(reset),
        .alloc_req_cnt(alloc_req_cnt), .alloc_grant_cnt(alloc_grant_cnt),
        .alloc_preg(alloc_preg), .free_cnt(free_cnt),
        .complete_valid(complete_valid), .complete_preg(complete_preg),
        .retire_cnt(retire_cnt), .retire_preg(retire_preg),
        .ckpt_take(ckpt_take), .ckpt_tag(ckpt_tag), .ckpt_full(ckpt_full),
        .br_valid(br_valid), .br_tag(br_tag), .br_mispredict(br_mispredict),
        .ready_list(ready_list), .next_ready_list(next_ready_list)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: free/ready sets, checkpoints ordered by take sequence number.
    logic [NUM_PREGS-1:0] m_free, m_ready;
    bit                   m_cvalid [NUM_CKPT];
    int                   m_cseq   [NUM_CKPT];
    logic [NUM_PREGS-1:0] m_csnap  [NUM_CKPT];
    int                   seq_ctr;
    int                   txn = 0;

    int s_grant, s_p0, s_tag, s_fcnt, s_full;

    typedef struct {
        int req; int rcnt; int rp0; logic [2:0] cval; int cp1;
        bit take; bit bv; int btag; bit bmis;
        int e_grant; int e_p0; int e_tag; int e_fcnt; bit e_full;
    } vec_t;
    vec_t tbl [19];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int ones(input logic [NUM_PREGS-1:0] v);
        int n = 0;
        for (int i = 0; i < NUM_PREGS; i++) n += int'(v[i]);
        return n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_PREGS; i++) begin
            m_free[i]  = (i >= NUM_AREGS);
            m_ready[i] = (i < NUM_AREGS);
        end
        for (int c = 0; c < NUM_CKPT; c++) begin
            m_cvalid[c] = 0; m_cseq[c] = 0; m_csnap[c] = '0;
        end
        seq_ctr = 0;
    endtask

    task automatic clear_inputs();
        alloc_req_cnt = '0; retire_cnt = '0; retire_preg = '0;
        complete_valid = '0; complete_preg = '0;
        ckpt_take = 1'b0; br_valid = 1'b0; br_tag = '0; br_mispredict = 1'b0;
    endtask

    // Called at a negedge with inputs already driven; returns at the following negedge.
    task automatic step(input string name);
        int   exp_grant, nfree, k, slot, tgt, p;
        bit   mis, res, full, take_ok;
        logic [NUM_PREGS-1:0] alloc_set, retire_set, comp_set, after;
        #1;
        mis   = br_valid && br_mispredict && m_cvalid[br_tag];
        res   = br_valid && !br_mispredict && m_cvalid[br_tag];
        nfree = ones(m_free);
        exp_grant = mis ? 0 : ((int'(alloc_req_cnt) < nfree) ? int'(alloc_req_cnt) : nfree);
        check({name, ".grant"}, 64'(alloc_grant_cnt), 64'(exp_grant));
        alloc_set = '0; k = 0;
        for (int i = 0; i < NUM_PREGS; i++) begin
            if (m_free[i] && k < exp_grant) begin
                alloc_set[i] = 1'b1;
                check($sformatf("%s.alloc_preg%0d", name, k), 64'(alloc_preg[k*PREG_W +: PREG_W]), 64'(i));
                k++;
            end
        end
        retire_set = '0; comp_set = '0;
        for (int j = 0; j < WIDTH; j++) begin
            p = int'(retire_preg[j*PREG_W +: PREG_W]);
            if (j < int'(retire_cnt) && p != 0) retire_set[p] = 1'b1;
            if (complete_valid[j]) comp_set[complete_preg[j*PREG_W +: PREG_W]] = 1'b1;
        end
        check({name, ".next_ready"}, next_ready_list, m_ready | comp_set);
        full = 1; slot = -1;
        for (int c = NUM_CKPT - 1; c >= 0; c--) if (!m_cvalid[c]) begin full = 0; slot = c; end
        take_ok = ckpt_take && !full && !mis;
        if (take_ok) check({name, ".ckpt_tag"}, 64'(ckpt_tag), 64'(slot));
        s_grant = int'(alloc_grant_cnt); s_p0 = int'(alloc_preg[PREG_W-1:0]); s_tag = int'(ckpt_tag);

        after = (m_free & ~alloc_set) | retire_set;
        if (mis) begin
            tgt = m_cseq[br_tag];
            m_free = m_csnap[br_tag] | retire_set;
            for (int c = 0; c < NUM_CKPT; c++) if (m_cvalid[c] && m_cseq[c] >= tgt) m_cvalid[c] = 0;
        end else begin
            m_free = after;
        end
        for (int c = 0; c < NUM_CKPT; c++) if (m_cvalid[c]) m_csnap[c] = m_csnap[c] | retire_set;
        if (res) m_cvalid[br_tag] = 0;
        if (take_ok) begin
            m_cvalid[slot] = 1; m_cseq[slot] = seq_ctr; m_csnap[slot] = after; seq_ctr++;
        end
        m_ready = (m_ready & ~alloc_set) | comp_set;

        @(posedge clock); #1;
        full = 1;
        for (int c = 0; c < NUM_CKPT; c++) if (!m_cvalid[c]) full = 0;
        check({name, ".free_cnt"}, 64'(free_cnt), 64'(ones(m_free)));
        check({name, ".ready_list"}, ready_list, m_ready);
        check({name, ".ckpt_full"}, 64'(ckpt_full), 64'(full));
        s_fcnt = int'(free_cnt); s_full = int'(ckpt_full);
        $display("txn %0d %s req=%0d grant=%0d p0=%0d take=%0b tag=%0d br=%0b/%0d/%0b ret=%0d free_cnt=%0d full=%0b",
                 txn, name, alloc_req_cnt, s_grant, s_p0, ckpt_take, s_tag, br_valid, br_tag,
                 br_mispredict, retire_cnt, s_fcnt, s_full);
        txn++;
        @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard, want, cnt, p;
        logic [NUM_PREGS-1:0] chosen;
        int picked [$];

        //            req rc rp0 cval  cp1 tk bv bt bm  eg  ep0 etag efc ef
        tbl[0]  = '{3, 0, 0, 3'b000, 0, 0, 0, 0, 0,  3, 32, -1, 29, 0};
        tbl[1]  = '{0, 0, 0, 3'b010, 40,0, 0, 0, 0,  0, -1, -1, 29, 0};
        tbl[2]  = '{0, 0, 0, 3'b000, 0, 1, 0, 0, 0,  0, -1,  0, 29, 0};
        tbl[3]  = '{3, 1, 5, 3'b000, 0, 0, 0, 0, 0,  3, 35, -1, 27, 0};
        tbl[4]  = '{0, 0, 0, 3'b000, 0, 0, 1, 0, 1,  0, -1, -1, 30, 0};
        tbl[5]  = '{3, 0, 0, 3'b000, 0, 0, 0, 0, 0,  3,  5, -1, 27, 0};
        tbl[6]  = '{0, 0, 0, 3'b000, 0, 1, 0, 0, 0,  0, -1,  0, 27, 0};
        tbl[7]  = '{0, 0, 0, 3'b000, 0, 1, 0, 0, 0,  0, -1,  1, 27, 0};
        tbl[8]  = '{0, 0, 0, 3'b000, 0, 1, 0, 0, 0,  0, -1,  2, 27, 0};
        tbl[9]  = '{0, 0, 0, 3'b000, 0, 1, 0, 0, 0,  0, -1,  3, 27, 1};
        tbl[10] = '{0, 0, 0, 3'b000, 0, 1, 0, 0, 0,  0, -1, -1, 27, 1};
        tbl[11] = '{0, 0, 0, 3'b000, 0, 0, 1, 1, 1,  0, -1, -1, 27, 0};
        tbl[12] = '{0, 0, 0, 3'b000, 0, 0, 1, 0, 0,  0, -1, -1, 27, 0};
        tbl[13] = '{0, 0, 0, 3'b000, 0, 1, 0, 0, 0,  0, -1,  0, 27, 0};
        tbl[14] = '{2, 0, 0, 3'b000, 0, 1, 1, 0, 1,  0, -1, -1, 27, 0};
        tbl[15] = '{0, 0, 0, 3'b000, 0, 1, 0, 0, 0,  0, -1,  0, 27, 0};
        tbl[16] = '{0, 0, 0, 3'b000, 0, 1, 0, 0, 0,  0, -1,  1, 27, 0};
        tbl[17] = '{0, 1, 0, 3'b000, 0, 0, 0, 0, 0,  0, -1, -1, 27, 0};
        tbl[18] = '{3, 0, 0, 3'b000, 0, 0, 0, 0, 0,  3, 37, -1, 24, 0};

        reset = 1'b0;
        clear_inputs();
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check("reset.free_cnt", 64'(free_cnt), 64'd32);
        check("reset.ready_list", ready_list, 64'h0000_0000_FFFF_FFFF);
        check("reset.ckpt_full", 64'(ckpt_full), 64'd0);
        @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < 19; i++) begin
            clear_inputs();
            alloc_req_cnt  = CNT_W'(tbl[i].req);
            retire_cnt     = CNT_W'(tbl[i].rcnt);
            retire_preg[PREG_W-1:0] = PREG_W'(tbl[i].rp0);
            complete_valid = tbl[i].cval;
            complete_preg[PREG_W +: PREG_W] = PREG_W'(tbl[i].cp1);
            ckpt_take      = tbl[i].take;
            br_valid       = tbl[i].bv;
            br_tag         = CKPT_W'(tbl[i].btag);
            br_mispredict  = tbl[i].bmis;
            step($sformatf("vec%0d", i));
            check($sformatf("vec%0d.tbl_grant", i), 64'(s_grant), 64'(tbl[i].e_grant));
            if (tbl[i].e_p0 >= 0) check($sformatf("vec%0d.tbl_p0", i), 64'(s_p0), 64'(tbl[i].e_p0));
            if (tbl[i].e_tag >= 0) check($sformatf("vec%0d.tbl_tag", i), 64'(s_tag), 64'(tbl[i].e_tag));
            check($sformatf("vec%0d.tbl_free_cnt", i), 64'(s_fcnt), 64'(tbl[i].e_fcnt));
            check($sformatf("vec%0d.tbl_full", i), 64'(s_full), 64'(tbl[i].e_full));
        end

        // Drain to two free pregs, then under-grant and an empty-list request.
        guard = 0;
        while (ones(m_free) > 2 && guard < 40) begin
            clear_inputs();
            want = ones(m_free) - 2;
            alloc_req_cnt = CNT_W'((want > 3) ? 3 : want);
            step("drain");
            guard++;
        end
        check("drain.reached_two", 64'(free_cnt), 64'd2);
        clear_inputs();
        alloc_req_cnt = 3;
        step("undergrant");
        check("undergrant.grant", 64'(s_grant), 64'd2);
        check("undergrant.free_cnt", 64'(s_fcnt), 64'd0);
        clear_inputs();
        alloc_req_cnt = 1;
        step("empty");
        check("empty.grant", 64'(s_grant), 64'd0);

        // Asynchronous reset in the middle of a cycle.
        clear_inputs();
        alloc_req_cnt = 3;
        #2 reset = 1'b0;
        #1;
        check("midreset.free_cnt", 64'(free_cnt), 64'd32);
        check("midreset.ready_list", ready_list, 64'h0000_0000_FFFF_FFFF);
        check("midreset.ckpt_full", 64'(ckpt_full), 64'd0);
        check("midreset.grant", 64'(alloc_grant_cnt), 64'd3);
        check("midreset.alloc_preg0", 64'(alloc_preg[PREG_W-1:0]), 64'd32);
        @(negedge clock);
        reset = 1'b1;
        model_reset();
        clear_inputs();

        for (int n = 0; n < 400; n++) begin
            clear_inputs();
            alloc_req_cnt = CNT_W'($urandom_range(0, 3));
            for (int j = 0; j < WIDTH; j++) begin
                complete_valid[j] = ($urandom_range(0, 2) == 0);
                complete_preg[j*PREG_W +: PREG_W] = PREG_W'($urandom_range(0, NUM_PREGS - 1));
            end
            cnt = $urandom_range(0, 3);
            picked.delete();
            chosen = '0;
            for (int t = 0; t < 16 && picked.size() < cnt; t++) begin
                p = $urandom_range(1, NUM_PREGS - 1);
                if (!m_free[p] && !chosen[p]) begin
                    chosen[p] = 1'b1;
                    picked.push_back(p);
                end
            end
            for (int j = 0; j < picked.size(); j++) retire_preg[j*PREG_W +: PREG_W] = PREG_W'(picked[j]);
            retire_cnt    = CNT_W'(picked.size());
            ckpt_take     = ($urandom_range(0, 3) == 0);
            br_valid      = ($urandom_range(0, 4) == 0);
            br_tag        = CKPT_W'($urandom_range(0, NUM_CKPT - 1));
            br_mispredict = $urandom_range(0, 1) == 1;
            step("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
